// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI burst controller and its FIFOs.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Occupancy counters need to represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; a pop frees a slot for a push in the same cycle.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic                          in_ready,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          out_valid,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [LW-1:0]         level_reg;
    logic                  full;
    logic                  push_fire;
    logic                  pop_fire;

    assign full      = (level_reg == LW'(DEPTH));
    assign out_valid = (level_reg != '0);
    assign pop_fire  = pop && out_valid;
    assign in_ready  = !full || pop_fire;
    assign push_fire = push && in_ready;
    assign rdata     = mem[rd_ptr_reg];
    assign level     = level_reg;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_fire && !flush && !reset) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Queues bytes for spi_master, issues one go per byte and collects each datao into an RX FIFO.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               flush,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    input  logic [DATA_WIDTH-1:0]              tx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [DATA_WIDTH-1:0]              rx_data,
    output logic [level_width(FIFO_DEPTH)-1:0] tx_level,
    output logic [level_width(FIFO_DEPTH)-1:0] rx_level,
    output logic                               idle,
    output logic                               timeout_err,
    output logic                               spi_go,
    output logic [DATA_WIDTH-1:0]              spi_datai,
    input  logic                               spi_busy,
    input  logic                               spi_done,
    input  logic [DATA_WIDTH-1:0]              spi_datao
);

    localparam int LW = level_width(FIFO_DEPTH);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    state_t                state_reg;
    state_t                state_next;
    logic                  go_reg;
    logic [DATA_WIDTH-1:0] datai_reg;
    logic [CW-1:0]         tmo_cnt_reg;
    logic                  done_seen_reg;
    logic                  err_reg;

    logic                  tx_pop;
    logic                  tx_nonempty;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  capture;
    logic                  rx_push;
    logic                  rx_room;
    logic                  timeout_hit;
    logic                  inflight;
    logic [LW:0]           committed;
    logic                  can_launch;

    spi_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (tx_valid),
        .wdata     (tx_data),
        .in_ready  (tx_ready),
        .pop       (tx_pop),
        .rdata     (tx_head),
        .out_valid (tx_nonempty),
        .level     (tx_level)
    );

    spi_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (rx_push),
        .wdata     (spi_datao),
        .in_ready  (rx_room),
        .pop       (rx_ready),
        .rdata     (rx_data),
        .out_valid (rx_valid),
        .level     (rx_level)
    );

    // A transfer still owes an RX word until its done has been captured.
    assign inflight   = (state_reg != IDLE) && !done_seen_reg;
    assign committed  = {1'b0, rx_level} + {{LW{1'b0}}, inflight};
    assign can_launch = enable && tx_nonempty && !flush &&
                        (committed < (LW + 1)'(FIFO_DEPTH));
    assign rx_push    = capture && rx_room;

    always_comb begin
        state_next  = state_reg;
        tx_pop      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (can_launch) begin
                    tx_pop     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (spi_done) begin
                    capture    = 1'b1;
                    state_next = WAIT_DONE;
                end else if (spi_busy) begin
                    state_next = WAIT_DONE;
                end else if (tmo_cnt_reg == CW'(BUSY_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (done_seen_reg) begin
                    if (!spi_busy) begin
                        state_next = IDLE;
                    end
                end else if (spi_done) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // go and datai are registered together so datai is stable whenever go is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            go_reg        <= 1'b0;
            datai_reg     <= '0;
            tmo_cnt_reg   <= '0;
            done_seen_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            go_reg    <= tx_pop;
            if (tx_pop) begin
                datai_reg <= tx_head;
            end
            if (state_reg == LAUNCH) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg == WAIT_BUSY) begin
                tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
            end
            if (tx_pop) begin
                done_seen_reg <= 1'b0;
            end else if (state_reg == WAIT_BUSY && spi_done) begin
                done_seen_reg <= 1'b1;
            end
            if (timeout_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign spi_go      = go_reg;
    assign spi_datai   = datai_reg;
    assign timeout_err = err_reg;
    assign idle        = (state_reg == IDLE) && (tx_level == '0);

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a behavioural spi_master stand-in.
module tb_spi_burst_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       flush = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic [3:0] tx_level;
    logic [3:0] rx_level;
    logic       idle;
    logic       timeout_err;
    logic       spi_go;
    logic [7:0] spi_datai;
    logic       spi_busy = 1'b0;
    logic       spi_done = 1'b0;
    logic [7:0] spi_datao = 8'h00;

    int checks = 0;
    int passes = 0;

    // Stand-in master: 0 = normal transfer, 1 = never busy, 2 = done without busy.
    int         stub_mode = 0;
    int         xfer_len = 3;
    logic [7:0] mask = 8'h00;
    int         stub_cnt = 0;
    logic       go_pend = 1'b0;
    int         go_count = 0;
    int         go_wide = 0;
    logic       go_prev = 1'b0;

    spi_burst_ctrl #(
        .DATA_WIDTH   (8),
        .FIFO_DEPTH   (8),
        .BUSY_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .flush       (flush),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .idle        (idle),
        .timeout_err (timeout_err),
        .spi_go      (spi_go),
        .spi_datai   (spi_datai),
        .spi_busy    (spi_busy),
        .spi_done    (spi_done),
        .spi_datao   (spi_datao)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        spi_done <= 1'b0;
        go_pend  <= (spi_go === 1'b1);
        if (go_pend) begin
            if (stub_mode == 0) begin
                spi_busy <= 1'b1;
                stub_cnt <= xfer_len;
            end else if (stub_mode == 2) begin
                spi_done  <= 1'b1;
                spi_datao <= spi_datai ^ mask;
            end
        end else if (spi_busy) begin
            if (stub_cnt == 0) begin
                spi_busy  <= 1'b0;
                spi_done  <= 1'b1;
                spi_datao <= spi_datai ^ mask;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (spi_go === 1'b1) begin
            go_count = go_count + 1;
            if (go_prev) go_wide = go_wide + 1;
        end
        go_prev = (spi_go === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        reset = 1'b1; enable = 1'b0; flush = 1'b0;
        tx_valid = 1'b0; rx_ready = 1'b0; stub_mode = 0; mask = 8'h00; xfer_len = 3;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        go_count = 0;
        go_wide = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            $display("FAIL push_wait tx_ready=%0b required 1 for byte %h", tx_ready, b);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_byte(output logic [7:0] b, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!rx_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = rx_valid;
        b  = rx_data;
        if (ok) begin
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!idle && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = idle;
    endtask

    task automatic wait_go(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!spi_go && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = spi_go;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({spi_go, tx_ready, rx_valid, idle, timeout_err} !== 5'b01010) begin
            $display("FAIL %s_flags go/txr/rxv/idle/err=%b required 01010", tag,
                     {spi_go, tx_ready, rx_valid, idle, timeout_err});
        end else passes++;
        checks++;
        if (tx_level !== 4'd0 || rx_level !== 4'd0) begin
            $display("FAIL %s_levels tx=%0d rx=%0d required 0 0", tag, tx_level, rx_level);
        end else passes++;
        checks++;
        if (spi_datai !== 8'h00) begin
            $display("FAIL %s_datai got %h required 00", tag, spi_datai);
        end else passes++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_loopback;
        logic [7:0] vec [4];
        logic [7:0] b;
        bit ok;
        vec = '{8'h00, 8'hA5, 8'h3C, 8'hFF};
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(vec[i]);
        wait_idle(ok);
        checks++;
        if (!ok || rx_level !== 4'd4) begin
            $display("FAIL loop_level idle=%0b rx_level=%0d required 1 4", ok, rx_level);
        end else passes++;
        checks++;
        if (go_count !== 4 || go_wide !== 0) begin
            $display("FAIL loop_go pulses=%0d wide=%0d required 4 0", go_count, go_wide);
        end else passes++;
        for (int i = 0; i < 4; i++) begin
            pop_byte(b, ok);
            checks++;
            if (!ok || b !== vec[i]) begin
                $display("FAIL loop_rx%0d got %h required %h", i, b, vec[i]);
            end else passes++;
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            $display("FAIL loop_err got %b required 0", timeout_err);
        end else passes++;
    endtask

    task automatic test_masked_burst;
        logic [7:0] vec [8];
        logic [7:0] exp [8];
        logic [7:0] b;
        bit ok;
        vec = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'h55, 8'hAA, 8'h0F, 8'hF0};
        exp = '{8'h5B, 8'hDA, 8'h24, 8'h99, 8'h0F, 8'hF0, 8'h55, 8'hAA};
        do_reset();
        mask = 8'h5A;
        xfer_len = 1;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(vec[i]);
        wait_idle(ok);
        for (int i = 0; i < 8; i++) begin
            pop_byte(b, ok);
            checks++;
            if (!ok || b !== exp[i]) begin
                $display("FAIL burst_rx%0d got %h required %h", i, b, exp[i]);
            end else passes++;
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] b;
        bit ok;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 12; i++) push_byte(8'h20 + 8'(i));
        repeat (200) @(negedge clk);
        checks++;
        if (rx_level !== 4'd8 || tx_level !== 4'd4 || go_count !== 8) begin
            $display("FAIL bp_stall rx=%0d tx=%0d go=%0d required 8 4 8", rx_level, tx_level, go_count);
        end else passes++;
        checks++;
        if (rx_data !== 8'h20) begin
            $display("FAIL bp_head got %h required 20", rx_data);
        end else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_data !== 8'h20 || rx_valid !== 1'b1) begin
            $display("FAIL bp_hold got %h valid=%b required 20 1", rx_data, rx_valid);
        end else passes++;
        for (int i = 0; i < 12; i++) begin
            pop_byte(b, ok);
            checks++;
            if (!ok || b !== 8'h20 + 8'(i)) begin
                $display("FAIL bp_rx%0d got %h required %h", i, b, 8'h20 + 8'(i));
            end else passes++;
        end
        wait_idle(ok);
        checks++;
        if (!ok || go_count !== 12) begin
            $display("FAIL bp_total idle=%0b go=%0d required 1 12", ok, go_count);
        end else passes++;
    endtask

    task automatic test_full_simul;
        logic [7:0] b;
        bit ok;
        int n = 0;
        do_reset();
        for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i));
        checks++;
        if (tx_ready !== 1'b0 || tx_level !== 4'd8) begin
            $display("FAIL full_state ready=%b level=%0d required 0 8", tx_ready, tx_level);
        end else passes++;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hEE;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (tx_level !== 4'd8) begin
            $display("FAIL full_ignore level=%0d required 8", tx_level);
        end else passes++;
        // Launch pops the head in the same cycle that a new byte is written.
        enable   = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h99;
        @(negedge clk);
        enable   = 1'b0;
        tx_valid = 1'b0;
        checks++;
        if (tx_level !== 4'd8 || spi_go !== 1'b1) begin
            $display("FAIL full_simul level=%0d go=%b required 8 1", tx_level, spi_go);
        end else passes++;
        while (rx_level !== 4'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        pop_byte(b, ok);
        checks++;
        if (!ok || b !== 8'h40) begin
            $display("FAIL full_first got %h required 40", b);
        end else passes++;
        enable = 1'b1;
        wait_idle(ok);
        for (int i = 1; i < 9; i++) begin
            pop_byte(b, ok);
            checks++;
            if (i < 8) begin
                if (!ok || b !== 8'h40 + 8'(i)) begin
                    $display("FAIL full_rx%0d got %h required %h", i, b, 8'h40 + 8'(i));
                end else passes++;
            end else begin
                if (!ok || b !== 8'h99) begin
                    $display("FAIL full_rx%0d got %h required 99", i, b);
                end else passes++;
            end
        end
    endtask

    task automatic test_zero_len;
        logic [7:0] b;
        bit ok;
        do_reset();
        stub_mode = 2;
        mask = 8'h0F;
        enable = 1'b1;
        push_byte(8'h3C);
        wait_idle(ok);
        checks++;
        if (!ok || rx_level !== 4'd1 || timeout_err !== 1'b0) begin
            $display("FAIL zero_state idle=%0b rx=%0d err=%b required 1 1 0", ok, rx_level, timeout_err);
        end else passes++;
        pop_byte(b, ok);
        checks++;
        if (!ok || b !== 8'h33) begin
            $display("FAIL zero_rx got %h required 33", b);
        end else passes++;
        stub_mode = 0;
    endtask

    task automatic test_flush_mid;
        logic [7:0] b;
        bit ok;
        int n = 0;
        do_reset();
        xfer_len = 10;
        push_byte(8'h61);
        push_byte(8'h62);
        push_byte(8'h63);
        enable = 1'b1;
        wait_go(ok);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (tx_level !== 4'd0 || rx_level !== 4'd0 || rx_valid !== 1'b0) begin
            $display("FAIL flush_clear tx=%0d rx=%0d rxv=%b required 0 0 0", tx_level, rx_level, rx_valid);
        end else passes++;
        while (rx_level !== 4'd1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_level !== 4'd1) begin
            $display("FAIL flush_result rx_level=%0d required 1", rx_level);
        end else passes++;
        pop_byte(b, ok);
        checks++;
        if (!ok || b !== 8'h61 || go_count !== 1) begin
            $display("FAIL flush_rx got %h go=%0d required 61 1", b, go_count);
        end else passes++;
    endtask

    task automatic test_timeout;
        bit ok;
        int n = 0;
        do_reset();
        stub_mode = 1;
        push_byte(8'hA1);
        push_byte(8'hB2);
        enable = 1'b1;
        wait_go(ok);
        while (timeout_err !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (timeout_err !== 1'b1 || n != 16) begin
            $display("FAIL tmo_latency err=%b cycles=%0d required 1 16", timeout_err, n);
        end else passes++;
        wait_idle(ok);
        checks++;
        if (!ok || go_count !== 2 || rx_level !== 4'd0 || timeout_err !== 1'b1) begin
            $display("FAIL tmo_next idle=%0b go=%0d rx=%0d err=%b required 1 2 0 1",
                     ok, go_count, rx_level, timeout_err);
        end else passes++;
        enable = 1'b0;
        stub_mode = 0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset();
        xfer_len = 10;
        push_byte(8'h77);
        enable = 1'b1;
        wait_go(ok);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("rstmid");
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (rx_level !== 4'd0 || rx_valid !== 1'b0) begin
            $display("FAIL rstmid_rx rx_level=%0d rxv=%b required 0 0", rx_level, rx_valid);
        end else passes++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_masked_burst();
        test_backpressure();
        test_full_simul();
        test_zero_len();
        test_flush_mid();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
